shadow_rc_gen: RTL and testbench
================================

# shadow_rc_gen

Sequential round-constant generator for the Shadow-512 permutation core. It holds a 32-bit LFSR state and streams one constant per accepted handshake, NB_RC constants per permutation call. It then returns idle and reloads the seed. It sits directly upstream of the round datapath and instantiates the single-step LFSR update stage as its next-state function.

## Interface
Parameters:
- POLY, 32'hc5: feedback polynomial; XORed in when the outgoing MSB is 1.
- SEED, 32'h00000001: LFSR value loaded at reset, on start, and after the last constant; must be nonzero.
- NB_RC, 12: constants per permutation call; must be at least 2.
- IDX_W, $clog2(NB_RC): width of rc_idx.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: pulse that begins a call; honoured only in IDLE.
- busy, output, 1: high in RUN.
- rc, output, 32: current round constant (the registered LFSR state).
- rc_valid, output, 1: rc is valid.
- rc_ready, input, 1: consumer accepts rc.
- rc_idx, output, IDX_W: index of rc within the call, 0..NB_RC-1.
- rc_last, output, 1: rc_valid && rc_idx == NB_RC-1.
- done, output, 1: one-cycle pulse after the last constant is accepted.

## Operation
- FSM states: IDLE, RUN.
- Handshake event: hs = rc_valid && rc_ready.
- IDLE:
  - rc_valid = 0 and busy = 0.
  - LFSR holds SEED.
  - start moves to RUN, reloads SEED and clears rc_idx.
- RUN:
  - rc_valid = 1 and busy = 1.
  - On hs with rc_idx < NB_RC-1: LFSR becomes (rc << 1) ^ (rc[31] ? POLY : 0); rc_idx increments.
  - On hs with rc_idx == NB_RC-1: go to IDLE, reload SEED, clear rc_idx, pulse done next cycle.
  - Without hs: rc and rc_idx hold; rc_valid stays high.
- start while in RUN is ignored, including the cycle of the final hs. A start one cycle later, in IDLE, is accepted.
- rc_ready is don't-care in IDLE. No state change occurs without rc_valid.
- Arithmetic:
  - The shift drops bit 31 with no carry out.
  - The LFSR is never zero when SEED != 0.
  - rc_idx never exceeds NB_RC-1 and never wraps within a call.
- Reset, including assertion mid-call:
  - Outputs go to IDLE values immediately: rc = SEED, rc_valid = 0, rc_idx = 0, rc_last = 0, busy = 0, done = 0.
  - The in-flight call is abandoned.
  - No done is issued for it.

## Timing
- start sampled at edge t in IDLE → rc_valid = 1, rc = SEED, rc_idx = 0 after edge t.
- hs at edge k → next constant visible after edge k. Sustained rate is one constant per cycle with rc_ready tied high.
- A full call with rc_ready tied high:
  - start at t → constants valid from t+1 through t+NB_RC.
  - done high for the cycle after edge t+NB_RC.
  - Next start is accepted at edge t+NB_RC+1 at the earliest.
- done is registered, one cycle wide, and coincides with the first IDLE cycle.
- rc, rc_idx and rc_last are all registered (rc_last decoded from registers only); no combinational path from rc_ready or start to any output.

## Structure
- Shared package shadow_rc_pkg:
  - FSM state enum: IDLE, RUN.
  - Default constants: RC_POLY = 32'hc5, RC_SEED = 32'h1, RC_NB = 12.
- Sub-module: one instance of the existing 32-bit LFSR stage upd_lfsr, parameterised with POLY.
  - Fed by the rc register; its output is the next-state value on hs.
- Everything else is local: the FSM, the LFSR register, the index counter and the done flop.

## Test plan
- Reset, then start with rc_ready = 1 → rc = 1, 2, 4, …, 0x800 on 12 consecutive cycles; rc_idx 0..11; rc_last only on 0x800; done one cycle later; busy low after.
- SEED = 32'h80000000 → sequence 0x80000000, 0x000000c5, 0x0000018a, checking the feedback path.
- rc_ready toggled randomly (about 50%) → rc and rc_idx stable whenever rc_ready = 0; same 12-value sequence; done after exactly 12 handshakes.
- start pulsed at rc_idx = 5 and again on the final-hs cycle → both ignored. start on the first IDLE cycle → new call from rc = 1, rc_idx = 0.
- rst_n asserted mid-call at rc_idx = 7 → outputs at reset values asynchronously, with no done. After release and start → sequence restarts at 1.
- NB_RC = 2 → exactly two constants (1, 2); rc_last on the second; done one cycle after; back-to-back calls repeat 1, 2.

Source files
------------

// File: rtl/shadow_rc_pkg.sv
// Shared types and default constants for the Shadow-512 round-constant generator.
package shadow_rc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [31:0] RC_POLY = 32'hc5;
    localparam logic [31:0] RC_SEED = 32'h0000_0001;
    localparam int          RC_NB   = 12;

endpackage

// File: rtl/shadow_rc_gen_lfsr.sv
// Single-step 32-bit Galois LFSR update: shift left, fold POLY back in when the MSB leaves.
module upd_lfsr #(
    parameter logic [31:0] POLY = 32'hc5
) (
    input  logic [31:0] state,
    output logic [31:0] next
);

    assign next = {state[30:0], 1'b0} ^ (state[31] ? POLY : 32'h0);

endmodule

// File: rtl/shadow_rc_gen.sv
// Round-constant generator: streams NB_RC LFSR values per call over a valid/ready
// handshake, then reloads the seed and pulses done.
module shadow_rc_gen
    import shadow_rc_pkg::*;
#(
    parameter logic [31:0] POLY  = RC_POLY,
    parameter logic [31:0] SEED  = RC_SEED,
    parameter int          NB_RC = RC_NB,
    parameter int          IDX_W = $clog2(NB_RC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic [31:0]      rc,
    output logic             rc_valid,
    input  logic             rc_ready,
    output logic [IDX_W-1:0] rc_idx,
    output logic             rc_last,
    output logic             done
);

    state_t           state_reg, state_next;
    logic [31:0]      lfsr_reg, lfsr_next, lfsr_step;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             done_reg, done_next;
    logic             hs;
    logic             at_last;

    upd_lfsr #(.POLY(POLY)) u_upd_lfsr (
        .state (lfsr_reg),
        .next  (lfsr_step)
    );

    assign at_last = (idx_reg == IDX_W'(NB_RC - 1));
    assign hs      = rc_valid && rc_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            lfsr_reg  <= SEED;
            idx_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            lfsr_reg  <= lfsr_next;
            idx_reg   <= idx_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        lfsr_next  = lfsr_reg;
        idx_next   = idx_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    lfsr_next  = SEED;
                    idx_next   = '0;
                end
            end
            RUN: begin
                // start is deliberately not looked at here, even on the final handshake.
                if (hs) begin
                    if (at_last) begin
                        state_next = IDLE;
                        lfsr_next  = SEED;
                        idx_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        lfsr_next = lfsr_step;
                        idx_next  = idx_reg + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        rc_valid = 1'b0;
        case (state_reg)
            RUN: begin
                busy     = 1'b1;
                rc_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign rc      = lfsr_reg;
    assign rc_idx  = idx_reg;
    assign rc_last = rc_valid && at_last;
    assign done    = done_reg;

endmodule

// File: tb/tb_shadow_rc_gen.sv
// Scoreboard bench: three generator instances (default, MSB seed, NB_RC=2) checked
// against an arithmetic model of the constant sequence.
module tb_shadow_rc_gen;

    localparam logic [31:0] POLY = 32'hc5;

    typedef struct packed {
        logic [31:0] rc;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start    [3];
    logic        rc_ready [3];
    logic        busy     [3];
    logic        rc_valid [3];
    logic        rc_last  [3];
    logic        done     [3];
    logic [31:0] rc       [3];
    logic [3:0]  idx_w    [3];
    logic [0:0]  idx2;

    exp_t fifo [3][64];
    int   wr [3];
    int   rd [3];
    logic done_exp [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shadow_rc_gen #(.SEED(32'h0000_0001)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .rc(rc[0]),
        .rc_valid(rc_valid[0]), .rc_ready(rc_ready[0]), .rc_idx(idx_w[0]),
        .rc_last(rc_last[0]), .done(done[0])
    );

    shadow_rc_gen #(.SEED(32'h8000_0000)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .rc(rc[1]),
        .rc_valid(rc_valid[1]), .rc_ready(rc_ready[1]), .rc_idx(idx_w[1]),
        .rc_last(rc_last[1]), .done(done[1])
    );

    shadow_rc_gen #(.NB_RC(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .busy(busy[2]), .rc(rc[2]),
        .rc_valid(rc_valid[2]), .rc_ready(rc_ready[2]), .rc_idx(idx2),
        .rc_last(rc_last[2]), .done(done[2])
    );

    assign idx_w[2] = {3'b000, idx2};

    function automatic logic [31:0] seed_of(input int k);
        return (k == 1) ? 32'h8000_0000 : 32'h0000_0001;
    endfunction

    function automatic int nb_of(input int k);
        return (k == 2) ? 2 : 12;
    endfunction

    // Doubling modulo 2^32, with the polynomial folded in when the doubling overflows.
    function automatic logic [31:0] next_const(input logic [31:0] v);
        logic [32:0] t;
        t = {1'b0, v} * 33'd2;
        return t[31:0] ^ (t[32] ? POLY : 32'h0);
    endfunction

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=0x%0h want=0x%0h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic push_call(input int k);
        logic [31:0] v;
        v = seed_of(k);
        for (int i = 0; i < nb_of(k); i++) begin
            fifo[k][wr[k] % 64] = '{rc: v, idx: 4'(i), last: (i == nb_of(k) - 1)};
            wr[k]++;
            v = next_const(v);
        end
    endtask

    // Called at posedge+1; expectations are queued once the accepting edge has passed.
    task automatic do_start(input int k);
        start[k] = 1'b1;
        @(posedge clk);
        #1;
        start[k] = 1'b0;
        push_call(k);
        $display("start dut%0d seed=0x%08h nb=%0d", k, seed_of(k), nb_of(k));
    endtask

    task automatic run_call(input int k, input bit rnd, input bit pulse, input int abort_at);
        int   budget;
        exp_t e;
        budget = 400;
        do_start(k);
        while (rd[k] != wr[k]) begin
            e = fifo[k][rd[k] % 64];
            if (abort_at >= 0 && int'(e.idx) == abort_at) return;
            rc_ready[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start[k]    = pulse && (e.idx == 4'd5 || e.idx == 4'd11);
            @(posedge clk);
            #1;
            start[k] = 1'b0;
            budget--;
            if (budget == 0) begin
                total++;
                bad++;
                $display("FAIL timeout dut%0d got=%0d_left want=0_left", k, wr[k] - rd[k]);
                return;
            end
        end
        rc_ready[k] = 1'b1;
    endtask

    task automatic chk_reset_values;
        for (int k = 0; k < 3; k++) begin
            chk("rst_rc", k, 64'(rc[k]), 64'(seed_of(k)));
            chk("rst_valid", k, 64'(rc_valid[k]), 64'd0);
            chk("rst_idx", k, 64'(idx_w[k]), 64'd0);
            chk("rst_last", k, 64'(rc_last[k]), 64'd0);
            chk("rst_busy", k, 64'(busy[k]), 64'd0);
            chk("rst_done", k, 64'(done[k]), 64'd0);
        end
    endtask

    // Monitor: samples on the falling edge, pops on every handshake.
    logic pend;
    exp_t cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                rd[k]       = wr[k];
                done_exp[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                pend = (rd[k] != wr[k]);
                chk("valid", k, 64'(rc_valid[k]), 64'(pend));
                chk("busy", k, 64'(busy[k]), 64'(pend));
                chk("done", k, 64'(done[k]), 64'(done_exp[k]));
                done_exp[k] = 1'b0;
                if (rc_valid[k] && pend) begin
                    cur = fifo[k][rd[k] % 64];
                    chk("rc", k, 64'(rc[k]), 64'(cur.rc));
                    chk("idx", k, 64'(idx_w[k]), 64'(cur.idx));
                    chk("last", k, 64'(rc_last[k]), 64'(cur.last));
                    if (rc_ready[k]) begin
                        $display("hs dut%0d idx=%0d rc=0x%08h last=%0d", k, idx_w[k], rc[k], rc_last[k]);
                        rd[k]++;
                        if (cur.last) done_exp[k] = 1'b1;
                    end
                end else if (!rc_valid[k]) begin
                    chk("idle_last", k, 64'(rc_last[k]), 64'd0);
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            start[k]    = 1'b0;
            rc_ready[k] = 1'b1;
            wr[k]       = 0;
            rd[k]       = 0;
            done_exp[k] = 1'b0;
        end
        #12;
        chk_reset_values();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_call(0, 1'b0, 1'b0, -1);
        run_call(1, 1'b0, 1'b0, -1);
        repeat (3) run_call(0, 1'b1, 1'b0, -1);

        // starts at idx 5 and on the final handshake must be ignored; the next one is not
        run_call(0, 1'b0, 1'b1, -1);
        run_call(0, 1'b0, 1'b0, -1);

        // reset mid-call abandons it without a done
        run_call(0, 1'b0, 1'b0, 7);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_values();
        $display("reset asserted mid-call dut0");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_call(0, 1'b0, 1'b0, -1);

        repeat (3) run_call(2, 1'b0, 1'b0, -1);
        repeat (2) run_call(2, 1'b1, 1'b0, -1);
        run_call(1, 1'b1, 1'b0, -1);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
